// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg
// Shared definitions for the memory responder: the data width, the default
// geometry and the FSM state encoding used by mem_responder and mem_array.
package mem_responder_pkg;

    localparam int DATA_W     = 32;
    localparam int DEPTH_DEF  = 512;
    localparam int ADDR_W_DEF = 9;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/mem_array.sv
// mem_array
// Word-wide storage for the memory responder. Inferred as block RAM: one
// synchronous write port and one registered read port sharing one address.
//
// Ports:
//   clock  - system clock, rising edge
//   clear  - synchronous active-low reset; clears only the read register,
//            and suppresses any write presented on the same edge
//   we     - write enable (writes wdata to mem[addr])
//   re     - read enable (loads rdata from mem[addr])
//   addr   - word address
//   wdata  - write data
//   rdata  - registered read data; holds until the next enabled read
module mem_array
    import mem_responder_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    // Storage is deliberately left unreset so it maps onto block RAM.
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_reg;

    // An access cut short by reset must not land in memory.
    always_ff @(posedge clock) begin
        if (we && clear) begin
            mem[addr] <= wdata;
        end
    end

    // Output register with synchronous reset, as supported by BRAM output latches.
    always_ff @(posedge clock) begin
        if (!clear) begin
            rdata_reg <= '0;
        end else if (re) begin
            rdata_reg <= mem[addr];
        end
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/mem_responder.sv
// mem_responder
// Handshaked memory slave for a simple datapath (MAR/MDR style). A request is
// accepted from IDLE only when "armed" (Read and Write seen low together since
// reset or since the last access), runs optional wait states in BUSY, and
// completes in DONE with a one-cycle ready pulse.
//
// Optional feature: define MEM_WAIT_STATE_EN to honour wait_cfg (0-3 extra
// wait cycles sampled at acceptance). Without it every access takes 1 cycle
// and wait_cfg is ignored.
//
// Ports:
//   clock    - system clock, rising edge
//   clear    - synchronous active-low reset
//   MARout   - word address
//   Read     - read request level, held until ready
//   Write    - write request level, held until ready
//   MDRdata  - write data
//   wait_cfg - extra wait cycles (used only with MEM_WAIT_STATE_EN)
//   Mdatain  - read data, held until the next completed read
//   ready    - one-cycle completion pulse (high in DONE)
//   busy     - high whenever the FSM is not in IDLE
//   err      - one-cycle pulse after Read and Write were requested together
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clock,
    input  logic              clear,
    input  logic [ADDR_W-1:0] MARout,
    input  logic              Read,
    input  logic              Write,
    input  logic [DATA_W-1:0] MDRdata,
    input  logic [1:0]        wait_cfg,
    output logic [DATA_W-1:0] Mdatain,
    output logic              ready,
    output logic              busy,
    output logic              err
);

    state_t              state_reg, state_next;
    logic                armed_reg, armed_next;
    logic [1:0]          cnt_reg, cnt_next;
    logic [ADDR_W-1:0]   addr_reg, addr_next;
    logic [DATA_W-1:0]   data_reg, data_next;
    logic                is_write_reg, is_write_next;
    logic                err_reg, err_next;

    logic                mem_we;
    logic                mem_re;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;

    logic [1:0]          eff_wait;
    logic                both_low;

`ifdef MEM_WAIT_STATE_EN
    assign eff_wait = wait_cfg;
`else
    assign eff_wait = 2'd0;
    logic unused_wait_cfg;
    assign unused_wait_cfg = ^wait_cfg;
`endif

    assign both_low = !Read && !Write;

    always_comb begin
        state_next    = state_reg;
        armed_next    = armed_reg;
        cnt_next      = cnt_reg;
        addr_next     = addr_reg;
        data_next     = data_reg;
        is_write_next = is_write_reg;
        err_next      = 1'b0;
        mem_we        = 1'b0;
        mem_re        = 1'b0;
        mem_addr      = addr_reg;
        mem_wdata     = data_reg;

        // Any edge that sees both request lines low re-arms acceptance,
        // including the DONE edge, so a one-cycle gap is enough between accesses.
        if (both_low) begin
            armed_next = 1'b1;
        end

        case (state_reg)
            IDLE: begin
                if (armed_reg) begin
                    if (Read && Write) begin
                        err_next = 1'b1;
                    end else if (Read != Write) begin
                        addr_next     = MARout;
                        data_next     = MDRdata;
                        is_write_next = Write;
                        armed_next    = 1'b0;
                        if (eff_wait != 2'd0) begin
                            state_next = BUSY;
                            cnt_next   = eff_wait;
                        end else begin
                            // Zero-wait access: this edge is the DONE entry, so
                            // the memory port takes the live inputs.
                            state_next = DONE;
                            mem_addr   = MARout;
                            mem_wdata  = MDRdata;
                            mem_we     = Write;
                            mem_re     = Read;
                        end
                    end
                end
            end

            BUSY: begin
                if (both_low) begin
                    state_next = IDLE;
                    cnt_next   = 2'd0;
                end else if (cnt_reg <= 2'd1) begin
                    state_next = DONE;
                    cnt_next   = 2'd0;
                    mem_we     = is_write_reg;
                    mem_re     = !is_write_reg;
                end else begin
                    cnt_next = cnt_reg - 2'd1;
                end
            end

            DONE: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!clear) begin
            state_reg    <= IDLE;
            armed_reg    <= 1'b0;
            cnt_reg      <= 2'd0;
            addr_reg     <= '0;
            data_reg     <= '0;
            is_write_reg <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            armed_reg    <= armed_next;
            cnt_reg      <= cnt_next;
            addr_reg     <= addr_next;
            data_reg     <= data_next;
            is_write_reg <= is_write_next;
            err_reg      <= err_next;
        end
    end

    mem_array #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem_array (
        .clock (clock),
        .clear (clear),
        .we    (mem_we),
        .re    (mem_re),
        .addr  (mem_addr),
        .wdata (mem_wdata),
        .rdata (Mdatain)
    );

    assign ready = (state_reg == DONE);
    assign busy  = (state_reg != IDLE);
    assign err   = err_reg;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder
// Directed and randomized checks of mem_responder against an associative-array
// memory model and latency rule (1 + effective wait). Build with or without
// MEM_WAIT_STATE_EN; expectations follow the same macro.
module tb_mem_responder;

    logic        clk;
    logic        clear;
    logic [8:0]  MARout;
    logic        Read;
    logic        Write;
    logic [31:0] MDRdata;
    logic [1:0]  wait_cfg;
    logic [31:0] Mdatain;
    logic        ready;
    logic        busy;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] ref_mem [logic [8:0]];
    logic [8:0]  addrs [8];

    mem_responder #(
        .DEPTH  (512),
        .ADDR_W (9)
    ) dut (
        .clock    (clk),
        .clear    (clear),
        .MARout   (MARout),
        .Read     (Read),
        .Write    (Write),
        .MDRdata  (MDRdata),
        .wait_cfg (wait_cfg),
        .Mdatain  (Mdatain),
        .ready    (ready),
        .busy     (busy),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int eff(input logic [1:0] wc);
`ifdef MEM_WAIT_STATE_EN
        return int'(wc);
`else
        return 0;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete handshake starting #1 after an edge with the block armed.
    // With jitter set, request fields are scrambled after acceptance to show
    // they were latched.
    task automatic access(input bit wr, input logic [8:0] a, input logic [31:0] d,
                          input logic [1:0] wc, input bit jitter);
        int          lat;
        int          exp_lat;
        logic [31:0] exp_rd;
        exp_lat = 1 + eff(wc);
        exp_rd  = 32'h0;
        if (!wr && ref_mem.exists(a)) exp_rd = ref_mem[a];
        MARout = a; MDRdata = d; wait_cfg = wc; Read = !wr; Write = wr;
        lat = 0;
        while (lat < 12) begin
            step();
            lat++;
            if (jitter) begin
                wait_cfg = 2'($urandom);
                MARout   = 9'($urandom);
                MDRdata  = $urandom;
            end
            if (ready) break;
        end
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("busy_at_ready", 32'(busy), 32'd1);
        chk("err_at_ready", 32'(err), 32'd0);
        if (!wr) chk("read_data", Mdatain, exp_rd);
        if (wr) ref_mem[a] = d;
        Read = 1'b0; Write = 1'b0;
        step();
        chk("ready_pulse", 32'(ready), 32'd0);
        chk("busy_after", 32'(busy), 32'd0);
        if (!wr) chk("read_hold", Mdatain, exp_rd);
        $display("access %s addr=%h data=%h wait_cfg=%0d latency=%0d expected_latency=%0d",
                 wr ? "WR" : "RD", a, wr ? d : Mdatain, wc, lat, exp_lat);
    endtask

    initial begin
        int          k;
        bit          wr;
        int          n_ready;
        int          gap;
        logic [31:0] v1;

        clear = 1'b0; MARout = '0; Read = 1'b0; Write = 1'b0; MDRdata = '0; wait_cfg = '0;
        repeat (3) step();
        chk("reset_ready", 32'(ready), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_err", 32'(err), 32'd0);
        chk("reset_mdatain", Mdatain, 32'd0);
        $display("reset applied: ready=%0d busy=%0d err=%0d Mdatain=%h", ready, busy, err, Mdatain);
        clear = 1'b1;
        step();

        // Basic write then read-back of the same word.
        access(1'b1, 9'h012, 32'h00000014, 2'd0, 1'b0);
        access(1'b0, 9'h012, 32'h0, 2'd0, 1'b0);

        // Top address, maximum wait, wait_cfg scrambled mid-access.
        access(1'b1, 9'h1FF, 32'hCAFEF00D, 2'd0, 1'b0);
        access(1'b0, 9'h1FF, 32'h0, 2'd3, 1'b1);

        // Simultaneous Read and Write: error pulse, no access.
        Read = 1'b1; Write = 1'b1; MARout = 9'h012; MDRdata = 32'hDEADBEEF;
        step();
        chk("err_pulse", 32'(err), 32'd1);
        chk("err_ready", 32'(ready), 32'd0);
        chk("err_busy", 32'(busy), 32'd0);
        Read = 1'b0; Write = 1'b0;
        step();
        chk("err_cleared", 32'(err), 32'd0);
        $display("illegal request RD+WR addr=012: err pulsed, no access");
        access(1'b0, 9'h012, 32'h0, 2'd0, 1'b0);

        // Write held high across DONE: one write, one ready.
        v1 = 32'h13579BDF;
        MARout = 9'h020; MDRdata = v1; wait_cfg = 2'd0; Write = 1'b1;
        n_ready = 0;
        repeat (6) begin
            step();
            if (ready) begin
                n_ready++;
                MDRdata = ~v1;
            end
        end
        chk("held_ready_count", 32'(n_ready), 32'd1);
        chk("held_no_restart", 32'(busy), 32'd0);
        Write = 1'b0;
        step();
        ref_mem[9'h020] = v1;
        $display("held write addr=020 data=%h ready_pulses=%0d", v1, n_ready);
        access(1'b0, 9'h020, 32'h0, 2'd0, 1'b0);

        // Reset during an in-flight write must not commit it.
        access(1'b1, 9'h005, 32'hA5A5A5A5, 2'd0, 1'b0);
`ifdef MEM_WAIT_STATE_EN
        MARout = 9'h005; MDRdata = 32'h12345678; wait_cfg = 2'd3; Write = 1'b1;
        step();
        chk("busy_in_wait", 32'(busy), 32'd1);
        clear = 1'b0;
        step();
`else
        access(1'b0, 9'h012, 32'h0, 2'd0, 1'b0);
        clear = 1'b0;
        step();
`endif
        chk("midreset_ready", 32'(ready), 32'd0);
        chk("midreset_busy", 32'(busy), 32'd0);
        chk("midreset_err", 32'(err), 32'd0);
        chk("midreset_mdatain", Mdatain, 32'd0);
        $display("reset mid-access: ready=%0d busy=%0d err=%0d Mdatain=%h", ready, busy, err, Mdatain);
        clear = 1'b1; Write = 1'b0; Read = 1'b0;
        step();
        access(1'b0, 9'h005, 32'h0, 2'd0, 1'b0);

`ifdef MEM_WAIT_STATE_EN
        // Abort: both request lines dropped during wait states.
        MARout = 9'h005; MDRdata = 32'hBAD0BAD0; wait_cfg = 2'd2; Write = 1'b1;
        step();
        chk("abort_busy", 32'(busy), 32'd1);
        Write = 1'b0;
        step();
        chk("abort_idle", 32'(busy), 32'd0);
        chk("abort_ready", 32'(ready), 32'd0);
        $display("aborted write addr=005 during wait");
        access(1'b0, 9'h005, 32'h0, 2'd0, 1'b0);
`endif

        // Randomized traffic over a small address pool.
        for (int i = 0; i < 8; i++) begin
            addrs[i] = 9'($urandom);
            access(1'b1, addrs[i], $urandom, 2'($urandom), 1'b1);
        end
        for (int i = 0; i < 40; i++) begin
            k  = $urandom_range(0, 7);
            wr = 1'($urandom_range(0, 1));
            access(wr, addrs[k], $urandom, 2'($urandom), 1'b1);
            gap = $urandom_range(0, 2);
            repeat (gap) step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
